apb_arb_master: RTL and testbench

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_arb_master_if.sv | 48 ++++
 rtl/apb_rr_arbiter.sv | 28 ++
 rtl/apb_arb_master.sv | 176 +++++++++++++++++
 tb/tb_apb_arb_master.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and sizes for the two-requester APB master.
// Holds the FSM state type, requester count, address/data widths,
// the slave-select bit position and a one-hot to index helper.
package apb_pkg;

   localparam int NREQ    = 2;
   localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int ADDR_W  = 8;   // requester-side address, includes slave select
   localparam int PADDR_W = 7;   // address presented on the APB bus
   localparam int DATA_W  = 8;
   localparam int SEL_BIT = 7;   // requester address bit choosing slave 2

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   // Converts a one-hot grant into the requester number it selects.
   function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = PTR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/apb_arb_master_if.sv
// apb_arb_master_if: requester-side handshake and APB bus signals.
//
// Requester handshake: requester i raises req_valid[i] with req_write,
// req_addr and req_wdata slice i stable, and holds them until it sees the
// one-cycle req_ready[i] pulse, which means the fields were captured. The
// result arrives later as a one-cycle resp_valid[i] pulse with resp_rdata
// and resp_err valid in that same cycle. There is no back-pressure on
// responses.
interface apb_arb_master_if;
   import apb_pkg::*;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_write;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        resp_valid;
   logic [DATA_W-1:0]      resp_rdata;
   logic                   resp_err;

   logic                   PSELECT1;
   logic                   PSELECT2;
   logic                   PENABLE;
   logic                   PWRITE;
   logic [PADDR_W-1:0]     PADDR;
   logic [DATA_W-1:0]      PWDATA;
   logic [DATA_W-1:0]      PRDATA1;
   logic [DATA_W-1:0]      PRDATA2;
   logic                   PREADY1;
   logic                   PREADY2;
   logic                   PSLVERR1;
   logic                   PSLVERR2;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA1, PRDATA2, PREADY1, PREADY2, PSLVERR1, PSLVERR2
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA1, PRDATA2, PREADY1, PREADY2, PSLVERR1, PSLVERR2
   );

endinterface

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin grant. The requester after last_ptr has
// the highest priority, so the last-granted requester wins only when it
// is the sole requester.
module apb_rr_arbiter
   import apb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] last_ptr,
   output logic [NREQ-1:0]  grant
);

   int unsigned      pos;
   logic [PTR_W-1:0] idx;

   // Scan requesters starting just after the last grant; first hit wins.
   always_comb begin
      grant = '0;
      pos   = 0;
      idx   = '0;
      for (int off = 1; off <= NREQ; off++) begin
         pos = int'(last_ptr) + off;
         if (pos >= NREQ) pos = pos - NREQ;
         idx = PTR_W'(pos);
         if (req[idx] && (grant == '0)) grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: two-requester round-robin APB master driving two slaves.
// Request address bit 7 picks the slave, bits 6:0 form PADDR.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase watchdog that
// aborts a transfer with resp_err=1 after TIMEOUT_CYCLES cycles.
// All outputs come from flops so the asynchronous reset clears them at once.
module apb_arb_master
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic              PCLK,
   input  logic              PRESET,
   apb_arb_master_if.master  bus,
   output apb_state_e        dbg_state
);

   apb_state_e         state_q, state_d;
   logic [PTR_W-1:0]   owner_q, owner_d;       // current / last granted requester
   logic               write_q, write_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [NREQ-1:0]    req_ready_q, req_ready_d;
   logic [NREQ-1:0]    resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
   logic               resp_err_q, resp_err_d;

   logic [NREQ-1:0]    grant;
   logic               take_req;
   logic               gnt_write;
   logic [ADDR_W-1:0]  gnt_addr;
   logic [DATA_W-1:0]  gnt_wdata;
   logic               sel_hi;
   logic               pready_sel;
   logic               pslverr_sel;
   logic [DATA_W-1:0]  prdata_sel;

`ifdef APB_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]            cnt_q, cnt_d;
`else
   // No watchdog in this build; the parameter is kept so both builds share
   // one parameter list, and a non-positive value is simply meaningless.
   if (TIMEOUT_CYCLES < 1) begin : g_unused_timeout
   end
`endif

   apb_rr_arbiter u_arb (
      .req      (bus.req_valid),
      .last_ptr (owner_q),
      .grant    (grant)
   );

   // Only the selected slave's return signals are ever looked at.
   assign sel_hi      = addr_q[SEL_BIT];
   assign pready_sel  = sel_hi ? bus.PREADY2  : bus.PREADY1;
   assign pslverr_sel = sel_hi ? bus.PSLVERR2 : bus.PSLVERR1;
   assign prdata_sel  = sel_hi ? bus.PRDATA2  : bus.PRDATA1;

   // Pick the granted requester's fields out of the packed request buses.
   always_comb begin
      gnt_write = 1'b0;
      gnt_addr  = '0;
      gnt_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gnt_write = bus.req_write[i];
            gnt_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
            gnt_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and registered-output logic for IDLE/SETUP/ACCESS.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      req_ready_d  = '0;
      resp_valid_d = '0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      take_req     = 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            take_req = |bus.req_valid;
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_ACCESS: begin
            if (pready_sel) begin
               resp_valid_d[owner_q] = 1'b1;
               resp_rdata_d          = write_q ? '0 : prdata_sel;
               resp_err_d            = pslverr_sel;
               state_d               = ST_IDLE;
               // Back-to-back: a waiting request goes straight to SETUP.
               take_req              = |bus.req_valid;
            end
`ifdef APB_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               resp_valid_d[owner_q] = 1'b1;
               resp_err_d            = 1'b1;
               state_d               = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (take_req) begin
         state_d     = ST_SETUP;
         owner_d     = onehot_to_idx(grant);
         write_d     = gnt_write;
         addr_d      = gnt_addr;
         wdata_d     = gnt_wdata;
         req_ready_d = grant;
      end
   end

   // State and output registers; reset leaves requester 0 first in line.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q      <= ST_IDLE;
         owner_q      <= PTR_W'(NREQ - 1);
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= '0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
`ifdef APB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign bus.PSELECT1   = (state_q != ST_IDLE) && !sel_hi;
   assign bus.PSELECT2   = (state_q != ST_IDLE) &&  sel_hi;
   assign bus.PENABLE    = (state_q == ST_ACCESS);
   assign bus.PWRITE     = write_q;
   assign bus.PADDR      = addr_q[PADDR_W-1:0];
   assign bus.PWDATA     = wdata_q;
   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: directed bench for apb_arb_master with requester
// drivers, a wait-state slave model and scoreboards for grants, APB
// phases and responses.
module tb_apb_arb_master;
   import apb_pkg::*;

   logic       pclk;
   logic       preset;
   apb_state_e dbg_state;

   apb_arb_master_if bus_if ();

   apb_arb_master #(.TIMEOUT_CYCLES(16)) u_dut (
      .PCLK      (pclk),
      .PRESET    (preset),
      .bus       (bus_if),
      .dbg_state (dbg_state)
   );

   int total = 0;
   int bad   = 0;
   int resp_cnt = 0;
   int slave_wait = 0;
   logic slave_err = 1'b0;
   int acc_cnt = 0;
   int acc_run = 0;
   int last_acc_len = 0;

   logic [16:0] rq0[$];      // {write, addr, wdata} waiting at requester 0
   logic [16:0] rq1[$];
   logic [0:0]  grant_q[$];  // expected grant order
   logic [16:0] apb_q[$];    // {slave2, write, paddr, pwdata}
   logic [9:0]  exp_q[$];    // {owner, err, rdata}
   logic [16:0] cur_apb = '0;
   logic [16:0] rq_item;
   logic [9:0]  exp_item;
   logic [0:0]  exp_gnt;

   // clock and watchdog
   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] slave_f(input logic [6:0] a);
      return {1'b0, a} ^ 8'h39;
   endfunction

   // Queue a request and its expected grant, APB transfer and response.
   task automatic post(input int r, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rd, input logic er, input bit want_resp);
      if (r == 0) rq0.push_back({w, a, d});
      else        rq1.push_back({w, a, d});
      grant_q.push_back(1'(r));
      apb_q.push_back({a[7], w, a[6:0], d});
      if (want_resp) exp_q.push_back({1'(r), er, (w ? 8'h00 : rd)});
   endtask

   task automatic wait_resp(input int target, input int budget, input string tag);
      int t;
      t = 0;
      while (resp_cnt < target && t < budget) begin
         @(negedge pclk); #1;
         t++;
      end
      check(tag, 32'(resp_cnt), 32'(target));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_psel1"},  32'(bus_if.PSELECT1),   32'(0));
      check({tag, "_psel2"},  32'(bus_if.PSELECT2),   32'(0));
      check({tag, "_pen"},    32'(bus_if.PENABLE),    32'(0));
      check({tag, "_pwrite"}, 32'(bus_if.PWRITE),     32'(0));
      check({tag, "_paddr"},  32'(bus_if.PADDR),      32'(0));
      check({tag, "_pwdata"}, 32'(bus_if.PWDATA),     32'(0));
      check({tag, "_ready"},  32'(bus_if.req_ready),  32'(0));
      check({tag, "_rvalid"}, 32'(bus_if.resp_valid), 32'(0));
      check({tag, "_rdata"},  32'(bus_if.resp_rdata), 32'(0));
      check({tag, "_rerr"},   32'(bus_if.resp_err),   32'(0));
      check({tag, "_state"},  32'(dbg_state),         32'(ST_IDLE));
   endtask

   // requester drivers: hold a request until its ready pulse, then load the next
   always @(negedge pclk) begin
      if (!preset) begin
         bus_if.req_valid = '0;
         bus_if.req_write = '0;
         bus_if.req_addr  = '0;
         bus_if.req_wdata = '0;
      end else begin
         if (bus_if.req_ready[0]) bus_if.req_valid[0] = 1'b0;
         if (bus_if.req_ready[1]) bus_if.req_valid[1] = 1'b0;
         if (!bus_if.req_valid[0] && rq0.size() != 0) begin
            rq_item = rq0.pop_front();
            bus_if.req_write[0]     = rq_item[16];
            bus_if.req_addr[7:0]    = rq_item[15:8];
            bus_if.req_wdata[7:0]   = rq_item[7:0];
            bus_if.req_valid[0]     = 1'b1;
         end
         if (!bus_if.req_valid[1] && rq1.size() != 0) begin
            rq_item = rq1.pop_front();
            bus_if.req_write[1]     = rq_item[16];
            bus_if.req_addr[15:8]   = rq_item[15:8];
            bus_if.req_wdata[15:8]  = rq_item[7:0];
            bus_if.req_valid[1]     = 1'b1;
         end
      end
   end

   // slave model: the unselected slave always claims ready with an error
   // and junk data, so any use of its returns shows up
   always @(negedge pclk) begin
      bus_if.PREADY1  = 1'b1;
      bus_if.PREADY2  = 1'b1;
      bus_if.PRDATA1  = 8'hEE;
      bus_if.PRDATA2  = 8'hEE;
      bus_if.PSLVERR1 = 1'b1;
      bus_if.PSLVERR2 = 1'b1;
      if (bus_if.PENABLE && (bus_if.PSELECT1 || bus_if.PSELECT2)) begin
         if (bus_if.PSELECT1) begin
            bus_if.PREADY1  = (acc_cnt == slave_wait);
            bus_if.PRDATA1  = slave_f(bus_if.PADDR);
            bus_if.PSLVERR1 = slave_err;
         end else begin
            bus_if.PREADY2  = (acc_cnt == slave_wait);
            bus_if.PRDATA2  = slave_f(bus_if.PADDR);
            bus_if.PSLVERR2 = slave_err;
         end
         acc_cnt++;
      end else begin
         acc_cnt = 0;
      end
   end

   // grant scoreboard
   always @(negedge pclk) begin
      if (preset && (bus_if.req_ready != 0)) begin
         if (grant_q.size() == 0) check("ready_unexpected", 32'(grant_q.size()), 32'(1));
         else begin
            exp_gnt = grant_q.pop_front();
            check("req_ready", 32'(bus_if.req_ready), 32'(2'b01 << exp_gnt));
         end
      end
   end

   // APB phase scoreboard and ACCESS-length measurement
   always @(negedge pclk) begin
      if (!preset) begin
         acc_run = 0;
      end else begin
         if (bus_if.PSELECT1 || bus_if.PSELECT2) begin
            if (!bus_if.PENABLE) begin
               if (apb_q.size() == 0) check("apb_unexpected_setup", 32'(apb_q.size()), 32'(1));
               else cur_apb = apb_q.pop_front();
            end
            check("apb_psel1",  32'(bus_if.PSELECT1), 32'(!cur_apb[16]));
            check("apb_psel2",  32'(bus_if.PSELECT2), 32'(cur_apb[16]));
            check("apb_pwrite", 32'(bus_if.PWRITE),   32'(cur_apb[15]));
            check("apb_paddr",  32'(bus_if.PADDR),    32'(cur_apb[14:8]));
            check("apb_pwdata", 32'(bus_if.PWDATA),   32'(cur_apb[7:0]));
         end else begin
            check("penable_without_psel", 32'(bus_if.PENABLE), 32'(0));
         end
         if (bus_if.PENABLE) acc_run++;
         else if (acc_run != 0) begin
            last_acc_len = acc_run;
            acc_run = 0;
         end
      end
   end

   // response scoreboard
   always @(negedge pclk) begin
      if (preset && (bus_if.resp_valid != 0)) begin
         if (exp_q.size() == 0) check("resp_unexpected", 32'(exp_q.size()), 32'(1));
         else begin
            exp_item = exp_q.pop_front();
            check("resp_valid", 32'(bus_if.resp_valid), 32'(2'b01 << exp_item[9]));
            check("resp_err",   32'(bus_if.resp_err),   32'(exp_item[8]));
            check("resp_rdata", 32'(bus_if.resp_rdata), 32'(exp_item[7:0]));
         end
         resp_cnt++;
      end
   end

   // directed sequence
   initial begin
      int t;
      int cyc;
      int idle_gaps;
      bit started;

      preset = 1'b0;
      repeat (3) @(negedge pclk);
      #1;
      check_all_zero("reset");
      preset = 1'b1;
      @(negedge pclk); #1;

      // requester 0 write to slave 1, zero wait states
      slave_wait = 0;
      post(0, 1'b1, 8'h05, 8'hA5, 8'h00, 1'b0, 1'b1);
      wait_resp(1, 20, "t1_resp_count");
      check("t1_access_len", 32'(last_acc_len), 32'(1));

      // requester 1 read from slave 2 with three wait states
      slave_wait = 3;
      post(1, 1'b0, 8'h85, 8'h00, 8'h3C, 1'b0, 1'b1);
      wait_resp(2, 30, "t2_resp_count");
      check("t2_access_len", 32'(last_acc_len), 32'(4));

      // slave error on a read
      slave_wait = 1;
      slave_err  = 1'b1;
      post(0, 1'b0, 8'h12, 8'h00, slave_f(7'h12), 1'b1, 1'b1);
      wait_resp(3, 30, "t3_resp_count");
      check("t3_access_len", 32'(last_acc_len), 32'(2));
      slave_err  = 1'b0;

      // reset in the middle of ACCESS: no response, everything cleared
      slave_wait = 5;
      post(1, 1'b1, 8'h90, 8'h77, 8'h00, 1'b0, 1'b0);
      t = 0;
      while (!bus_if.PENABLE && t < 20) begin
         @(negedge pclk); #1;
         t++;
      end
      check("t4_reach_access", 32'(bus_if.PENABLE), 32'(1));
      @(negedge pclk); #2;
      preset = 1'b0;
      #1;
      check_all_zero("t4_midreset");
      repeat (2) @(negedge pclk);
      #1;
      check("t4_no_resp", 32'(resp_cnt), 32'(3));
      preset = 1'b1;
      @(negedge pclk); #1;

      // both requesters busy: grants alternate 0,1,0,1 back to back
      slave_wait = 0;
      post(0, 1'b1, 8'h21, 8'h11, 8'h00, 1'b0, 1'b1);
      post(1, 1'b0, 8'hA2, 8'h00, slave_f(7'h22), 1'b0, 1'b1);
      post(0, 1'b0, 8'h33, 8'h00, slave_f(7'h33), 1'b0, 1'b1);
      post(1, 1'b1, 8'hC4, 8'h99, 8'h00, 1'b0, 1'b1);
      started = 1'b0;
      cyc = 0;
      idle_gaps = 0;
      t = 0;
      while (resp_cnt < 7 && t < 60) begin
         @(negedge pclk); #1;
         t++;
         if (started) cyc++;
         if (!started && bus_if.req_ready != 0) started = 1'b1;
         if (started && resp_cnt < 7 && dbg_state == ST_IDLE) idle_gaps++;
      end
      check("t5_resp_count", 32'(resp_cnt), 32'(7));
      check("t5_cycles", 32'(cyc), 32'(8));
      check("t5_idle_gaps", 32'(idle_gaps), 32'(0));
      check("t5_access_len", 32'(last_acc_len), 32'(1));

      // long stall: aborted by the watchdog or waited out
      slave_wait = 20;
`ifdef APB_TIMEOUT_EN
      post(0, 1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 1'b1);
      wait_resp(8, 40, "t6_resp_count");
      check("t6_access_len", 32'(last_acc_len), 32'(16));
`else
      post(0, 1'b0, 8'h07, 8'h00, slave_f(7'h07), 1'b0, 1'b1);
      wait_resp(8, 40, "t6_resp_count");
      check("t6_access_len", 32'(last_acc_len), 32'(21));
`endif
      @(negedge pclk); #1;
      check("t6_idle_state", 32'(dbg_state), 32'(ST_IDLE));
      check("t6_idle_psel", 32'({bus_if.PSELECT1, bus_if.PSELECT2, bus_if.PENABLE}), 32'(0));

      check("end_resp_q", 32'(exp_q.size()), 32'(0));
      check("end_grant_q", 32'(grant_q.size()), 32'(0));
      check("end_apb_q", 32'(apb_q.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
